uart_autobaud: RTL and testbench
================================

# uart_autobaud

Automatic baud-rate detector and configuration controller for the UART receive path. While enabled and unlocked, it gates the receiver and measures a sync character 0x55 on the RX line. It validates the edge timing and computes the bit length. It then drives the receiver's `i_bit_length` and releases it for normal traffic.

## Interface
- `DEFAULT_BIT_LENGTH`, default 867 — `o_bit_length` value after reset.
- `MIN_BIT_CLKS`, default 4 — minimum legal start-bit width in clocks.
- `MAX_BIT_CLKS`, default 1048576 — segment timeout in clocks.
- `IDLE_CLKS`, default 16 — consecutive high clocks required before arming.
- `i_clk` — input, 1 — clock. One clock; reset is asynchronous and active-low.
- `i_nrst` — input, 1 — asynchronous active-low reset.
- `i_enable` — input, 1 — level; high runs detection, low forces IDLE.
- `i_relock` — input, 1 — pulse; in LOCKED, starts a new measurement.
- `i_rx` — input, 1 — raw serial line; synchronized internally.
- `o_bit_length` — output, 32 — clocks per bit minus 1; feeds `uart_rx`/`uart_tx` `i_bit_length`.
- `o_locked` — output, 1 — level; a valid measured length is applied.
- `o_lock_pulse` — output, 1 — one-cycle pulse on each successful lock.
- `o_error` — output, 1 — one-cycle pulse on measurement failure.
- `o_err_cnt` — output, 8 — failed-measurement count, saturating at 255.
- `o_rx_block` — output, 1 — high while measuring; the receiver input is held idle-high.

## Operation
- **Synchronizer.** Two-flop synchronizer on `i_rx` gives `rx_s`; `rx_q` is `rx_s` delayed one cycle; `edge = rx_s ^ rx_q`.
- **Segment counter.** `seg_cnt` (32 bit) loads 1 on an edge cycle and increments otherwise. At the next edge the segment width w equals `seg_cnt`.
- **States.** IDLE, WAIT_IDLE, WAIT_START, MEASURE, CHECK_STOP, LOCKED.
  - IDLE: entered when `i_enable` is low, from any state. `i_enable` high moves to WAIT_IDLE.
  - WAIT_IDLE: counts consecutive `rx_s`=1 cycles; any low restarts the count. Reaching `IDLE_CLKS` moves to WAIT_START.
  - WAIT_START: a falling edge (start bit) clears `edge_idx` and `total`, then moves to MEASURE.
  - MEASURE: runs edges 1..8.
    - Edge 1: W1 = w. Error if W1 < `MIN_BIT_CLKS`.
    - Edges 2..8: error if w < W1 − (W1>>2) or w > W1 + (W1>>2).
    - `total` accumulates w for edges 1..8 (32 bit, no wrap: `MAX_BIT_CLKS`·8 < 2^32).
    - After edge 8 (falling into d7), move to CHECK_STOP.
  - CHECK_STOP: the rising edge into the stop bit is width-checked as above. On pass:
    - `o_bit_length` ← (`total`>>3) − 1.
    - `o_lock_pulse` = 1 for one cycle.
    - Move to LOCKED.
  - LOCKED: `o_locked`=1 and `o_rx_block`=0. `i_relock` moves to WAIT_IDLE with `o_locked`=0; `o_bit_length` holds its old value until the next lock.
- **Timeout.** In MEASURE or CHECK_STOP, `seg_cnt` > `MAX_BIT_CLKS` with no edge is an error.
- **Error handling.**
  - `o_error` pulses for one cycle.
  - `o_err_cnt` increments, saturating at 255.
  - State returns to WAIT_IDLE; `o_bit_length` is unchanged.
- **Simultaneous events.**
  - Width violation and timeout in the same cycle count as one error.
  - `i_enable` low overrides `i_relock`, an error, or a lock in the same cycle: no pulse is emitted, the state goes to IDLE.
- **`o_rx_block`.** High in WAIT_IDLE, WAIT_START, MEASURE and CHECK_STOP; low in IDLE and LOCKED.
- **Counter reset.** `o_err_cnt` clears only on reset.

## Timing
- **Reset values.** `o_bit_length` = `DEFAULT_BIT_LENGTH`. `o_locked`, `o_lock_pulse`, `o_error`, `o_rx_block` = 0. `o_err_cnt` = 0. State = IDLE. Synchronizer flops = 1.
- **Edge latency.** `edge` asserts 2 cycles after the clock that first samples the pin change. Equal latency on every edge means widths are exact.
- **Lock latency.** `o_locked`, `o_lock_pulse` and the new `o_bit_length` are visible the cycle after the edge-9 detect, i.e. 3 cycles after the pin rises into the stop bit. All three change in the same cycle.
- **Error latency.** `o_error` and `o_err_cnt` update the cycle after the offending edge or timeout cycle.
- **Measurement window.** The line is ignored after CHECK_STOP; the stop-bit high period is not measured.
- **Reset mid-measurement.** Returns to reset values immediately (asynchronous).
- **All outputs are registered.**

## Test plan
- **Exact sync.** Enable, 20 high clocks, then 0x55 LSB-first at 100 clk/bit → `o_bit_length`=99, one `o_lock_pulse`, `o_locked`=1, `o_rx_block`=0, `o_err_cnt`=0.
- **Jitter within tolerance.** Widths 100,90,110,90,110,90,110,100,100 (total of first 8 = 800) → `o_bit_length`=99, lock. W1 = 100 gives limits 75..125.
- **Width violation then recovery.** Third segment = 130 at 100 clk/bit → `o_error` pulse, `o_err_cnt`=1, `o_bit_length`=867, back to WAIT_IDLE. A clean 0x55 at 50 clk/bit then → `o_bit_length`=49.
- **Minimum and timeout.** Start bit of 3 clks → error. Separately, `MAX_BIT_CLKS`=1000 and line held low after the start → `o_error` 1001 cycles after the falling-edge detect.
- **Disable mid-measure.** Deassert `i_enable` at edge 5 → IDLE, `o_rx_block`=0, no error, `o_bit_length` unchanged. Re-enable plus clean sync → lock.
- **Relock and reset.** `i_relock` in LOCKED → `o_locked`=0, old length held; a new 0x55 at 200 clk/bit → 199. Assert `i_nrst` mid-MEASURE → all reset values, including `o_err_cnt`=0 and `o_bit_length`=867.

Source files
------------

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a 0x55 sync character on the RX line, validates the
// edge spacing and programs the receiver bit length. While measuring, the
// receiver is gated (o_rx_block) so the sync byte never reaches it.
module uart_autobaud #(
    parameter int unsigned DEFAULT_BIT_LENGTH = 867,
    parameter int unsigned MIN_BIT_CLKS       = 4,
    parameter int unsigned MAX_BIT_CLKS       = 1048576,
    parameter int unsigned IDLE_CLKS          = 16
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_enable,
    input  logic        i_relock,
    input  logic        i_rx,
    output logic [31:0] o_bit_length,
    output logic        o_locked,
    output logic        o_lock_pulse,
    output logic        o_error,
    output logic [7:0]  o_err_cnt,
    output logic        o_rx_block
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_WAIT_START,
        ST_MEASURE,
        ST_CHECK_STOP,
        ST_LOCKED
    } state_t;

    state_t      state_q;

    logic        rx_meta_q;
    logic        rx_s_q;
    logic        rx_dly_q;
    logic        rx_edge;

    logic [31:0] seg_cnt_q;
    logic [31:0] seg_cnt_d;
    logic [31:0] idle_cnt_q;
    logic [3:0]  edge_idx_q;
    logic [31:0] w1_q;
    logic [31:0] total_q;
    logic [31:0] bit_length_q;
    logic        locked_q;
    logic        lock_pulse_q;
    logic        error_q;
    logic [7:0]  err_cnt_q;
    logic [7:0]  err_cnt_d;
    logic        rx_block_q;

    logic [31:0] tol;
    logic [31:0] lo_lim;
    logic [31:0] hi_lim;
    logic        width_bad;
    logic        timeout;

    // Two-flop synchronizer plus one delay stage for edge detection; idle-high.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_dly_q  <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            rx_dly_q  <= rx_s_q;
        end
    end

    assign rx_edge = rx_s_q ^ rx_dly_q;

    // Segment width counter: reads the width of the segment ending at an edge.
    always_comb begin
        seg_cnt_d = seg_cnt_q;
        if (rx_edge) begin
            seg_cnt_d = 32'd1;
        end else if (seg_cnt_q != 32'hFFFF_FFFF) begin
            seg_cnt_d = seg_cnt_q + 32'd1;
        end
    end

    // Segment counter register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            seg_cnt_q <= 32'd0;
        end else begin
            seg_cnt_q <= seg_cnt_d;
        end
    end

    // Width acceptance window: first segment against the floor, later ones
    // within +/- 25% of the start-bit width.
    always_comb begin
        tol    = w1_q >> 2;
        lo_lim = w1_q - tol;
        hi_lim = w1_q + tol;
        if (edge_idx_q == 4'd0) begin
            width_bad = (seg_cnt_q < MIN_BIT_CLKS);
        end else begin
            width_bad = (seg_cnt_q < lo_lim) || (seg_cnt_q > hi_lim);
        end
        timeout   = !rx_edge && (seg_cnt_q > MAX_BIT_CLKS);
        err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);
    end

    // Detection state machine with registered status outputs.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= ST_IDLE;
            idle_cnt_q   <= 32'd0;
            edge_idx_q   <= 4'd0;
            w1_q         <= 32'd0;
            total_q      <= 32'd0;
            bit_length_q <= 32'(DEFAULT_BIT_LENGTH);
            locked_q     <= 1'b0;
            lock_pulse_q <= 1'b0;
            error_q      <= 1'b0;
            err_cnt_q    <= 8'd0;
            rx_block_q   <= 1'b0;
        end else begin
            lock_pulse_q <= 1'b0;
            error_q      <= 1'b0;
            if (!i_enable) begin
                // Disable wins over every other event in the same cycle.
                state_q    <= ST_IDLE;
                locked_q   <= 1'b0;
                rx_block_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q    <= ST_WAIT_IDLE;
                        idle_cnt_q <= 32'd0;
                        rx_block_q <= 1'b1;
                        locked_q   <= 1'b0;
                    end
                    ST_WAIT_IDLE: begin
                        if (rx_s_q) begin
                            if (idle_cnt_q == 32'(IDLE_CLKS - 1)) begin
                                state_q <= ST_WAIT_START;
                            end else begin
                                idle_cnt_q <= idle_cnt_q + 32'd1;
                            end
                        end else begin
                            idle_cnt_q <= 32'd0;
                        end
                    end
                    ST_WAIT_START: begin
                        if (rx_edge && !rx_s_q) begin
                            state_q    <= ST_MEASURE;
                            edge_idx_q <= 4'd0;
                            total_q    <= 32'd0;
                        end
                    end
                    ST_MEASURE: begin
                        if ((rx_edge && width_bad) || timeout) begin
                            state_q    <= ST_WAIT_IDLE;
                            idle_cnt_q <= 32'd0;
                            error_q    <= 1'b1;
                            err_cnt_q  <= err_cnt_d;
                        end else if (rx_edge) begin
                            if (edge_idx_q == 4'd0) begin
                                w1_q <= seg_cnt_q;
                            end
                            total_q    <= total_q + seg_cnt_q;
                            edge_idx_q <= edge_idx_q + 4'd1;
                            if (edge_idx_q == 4'd7) begin
                                state_q <= ST_CHECK_STOP;
                            end
                        end
                    end
                    ST_CHECK_STOP: begin
                        if ((rx_edge && width_bad) || timeout) begin
                            state_q    <= ST_WAIT_IDLE;
                            idle_cnt_q <= 32'd0;
                            error_q    <= 1'b1;
                            err_cnt_q  <= err_cnt_d;
                        end else if (rx_edge) begin
                            // Average of the eight measured segments, minus one.
                            bit_length_q <= (total_q >> 3) - 32'd1;
                            lock_pulse_q <= 1'b1;
                            locked_q     <= 1'b1;
                            rx_block_q   <= 1'b0;
                            state_q      <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        if (i_relock) begin
                            state_q    <= ST_WAIT_IDLE;
                            idle_cnt_q <= 32'd0;
                            locked_q   <= 1'b0;
                            rx_block_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        locked_q   <= 1'b0;
                        rx_block_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_bit_length = bit_length_q;
    assign o_locked     = locked_q;
    assign o_lock_pulse = lock_pulse_q;
    assign o_error      = error_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_rx_block   = rx_block_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud (timeout shortened to 1000 clocks).
module tb_uart_autobaud;

    logic        clk;
    logic        nrst;
    logic        en;
    logic        relock;
    logic        rx;
    logic [31:0] bit_length;
    logic        locked;
    logic        lock_pulse;
    logic        error;
    logic [7:0]  err_cnt;
    logic        rx_block;

    int n_total;
    int n_bad;
    int n_lock;
    int n_err;
    int w[9];

    uart_autobaud #(
        .DEFAULT_BIT_LENGTH(867),
        .MIN_BIT_CLKS(4),
        .MAX_BIT_CLKS(1000),
        .IDLE_CLKS(16)
    ) dut (
        .i_clk(clk),
        .i_nrst(nrst),
        .i_enable(en),
        .i_relock(relock),
        .i_rx(rx),
        .o_bit_length(bit_length),
        .o_locked(locked),
        .o_lock_pulse(lock_pulse),
        .o_error(error),
        .o_err_cnt(err_cnt),
        .o_rx_block(rx_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from output changes.
    initial begin
        n_lock = 0;
        n_err  = 0;
    end
    always @(negedge clk) begin
        if (lock_pulse) n_lock++;
        if (error) n_err++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Drive the first n segments of the sync frame (start bit low, then
    // alternating), then return the line high.
    task automatic send(input int ws[9], input int n);
        for (int i = 0; i < n; i++) begin
            rx = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(ws[i]);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        step(n);
    endtask

    // After the stop-bit rise: lock appears exactly three clocks later.
    task automatic expect_lock(input string tag, input logic [31:0] len);
        step(2);
        chk({tag, "_locked_early"}, {31'd0, locked}, 32'd0);
        step(1);
        chk({tag, "_locked"}, {31'd0, locked}, 32'd1);
        chk({tag, "_pulse"}, {31'd0, lock_pulse}, 32'd1);
        chk({tag, "_len"}, bit_length, len);
        chk({tag, "_rx_block"}, {31'd0, rx_block}, 32'd0);
        step(1);
        chk({tag, "_pulse_end"}, {31'd0, lock_pulse}, 32'd0);
    endtask

    // After an offending edge rise: error pulse exactly three clocks later.
    task automatic expect_err(input string tag, input logic [7:0] cnt, input logic [31:0] len);
        step(2);
        chk({tag, "_err_early"}, {31'd0, error}, 32'd0);
        step(1);
        chk({tag, "_err"}, {31'd0, error}, 32'd1);
        chk({tag, "_err_cnt"}, {24'd0, err_cnt}, {24'd0, cnt});
        chk({tag, "_len_held"}, bit_length, len);
        chk({tag, "_rx_block"}, {31'd0, rx_block}, 32'd1);
        step(1);
        chk({tag, "_err_end"}, {31'd0, error}, 32'd0);
    endtask

    task automatic do_relock(input string tag, input logic [31:0] len);
        relock = 1'b1;
        step(1);
        relock = 1'b0;
        chk({tag, "_unlocked"}, {31'd0, locked}, 32'd0);
        chk({tag, "_len_held"}, bit_length, len);
        chk({tag, "_rx_block"}, {31'd0, rx_block}, 32'd1);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        nrst    = 1'b0;
        en      = 1'b0;
        relock  = 1'b0;
        rx      = 1'b1;
        step(3);
        nrst = 1'b1;
        step(2);

        // Reset state
        chk("rst_len", bit_length, 32'd867);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_pulse", {31'd0, lock_pulse}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_rx_block", {31'd0, rx_block}, 32'd0);

        // Width violation: third segment 130 against W1=100 (limit 125)
        en = 1'b1;
        idle(20);
        chk("armed_rx_block", {31'd0, rx_block}, 32'd1);
        w = '{100, 100, 130, 100, 100, 100, 100, 100, 100};
        send(w, 3);
        expect_err("viol", 8'd1, 32'd867);

        // Recovery with a clean 50 clk/bit sync
        idle(20);
        w = '{default: 50};
        send(w, 9);
        expect_lock("s50", 32'd49);

        // Jitter within tolerance, sum of first eight = 800
        do_relock("rl1", 32'd49);
        idle(20);
        w = '{100, 90, 110, 90, 110, 90, 110, 100, 100};
        send(w, 9);
        expect_lock("jit", 32'd99);

        // Relock at 200 clk/bit
        do_relock("rl2", 32'd99);
        idle(20);
        w = '{default: 200};
        send(w, 9);
        expect_lock("s200", 32'd199);

        // Exact sync at 100 clk/bit
        do_relock("rl3", 32'd199);
        idle(20);
        w = '{default: 100};
        send(w, 9);
        expect_lock("s100", 32'd99);
        chk("s100_err_cnt", {24'd0, err_cnt}, 32'd1);

        // Start bit of 3 clocks is below the minimum
        do_relock("rl4", 32'd99);
        idle(20);
        w = '{default: 3};
        send(w, 1);
        expect_err("min3", 8'd2, 32'd99);

        // Exactly the minimum width locks
        idle(20);
        w = '{default: 4};
        send(w, 9);
        expect_lock("s4", 32'd3);

        // Timeout: line held low after the start edge
        do_relock("rl5", 32'd3);
        idle(20);
        rx = 1'b0;
        step(1003);
        chk("tmo_early", {31'd0, error}, 32'd0);
        step(1);
        chk("tmo_err", {31'd0, error}, 32'd1);
        chk("tmo_err_cnt", {24'd0, err_cnt}, 32'd3);
        chk("tmo_len_held", bit_length, 32'd3);
        rx = 1'b1;

        // Disable coincident with the edge-5 detect
        idle(20);
        w = '{default: 100};
        send(w, 5);
        step(2);
        en = 1'b0;
        step(1);
        chk("dis_rx_block", {31'd0, rx_block}, 32'd0);
        chk("dis_error", {31'd0, error}, 32'd0);
        chk("dis_locked", {31'd0, locked}, 32'd0);
        chk("dis_len", bit_length, 32'd3);
        step(300);
        chk("dis_err_cnt", {24'd0, err_cnt}, 32'd3);
        chk("dis_rx_block_idle", {31'd0, rx_block}, 32'd0);
        en = 1'b1;
        idle(20);
        send(w, 9);
        expect_lock("reen", 32'd99);

        chk("lock_pulse_total", n_lock, 32'd6);
        chk("err_pulse_total", n_err, 32'd3);

        // Asynchronous reset in the middle of a measurement
        do_relock("rl6", 32'd99);
        idle(20);
        w = '{default: 100};
        send(w, 3);
        step(5);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_len", bit_length, 32'd867);
        chk("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("arst_locked", {31'd0, locked}, 32'd0);
        chk("arst_rx_block", {31'd0, rx_block}, 32'd0);
        chk("arst_error", {31'd0, error}, 32'd0);
        step(2);
        en   = 1'b0;
        nrst = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
